// File: rtl/fc_argmax.sv
// Final LeNet classification stage: scans the FC scores held in SRAM e and reports
// the index and value of the largest signed score, holding the result with a valid flag.
module fc_argmax #(
   parameter int DATA_WIDTH             = 8,
   parameter int DATA_NUM_PER_SRAM_ADDR = 4,
   parameter int CLASS_NUM              = 10,
   parameter int ADDR_WIDTH             = 10,
   parameter int BASE_ADDR              = 0,
   parameter int IDX_WIDTH              = 4
) (
   input  logic                                         clk,
   input  logic                                         srstn,
   input  logic                                         argmax_start,
   input  logic [DATA_NUM_PER_SRAM_ADDR*DATA_WIDTH-1:0] sram_rdata_e,
   output logic [ADDR_WIDTH-1:0]                        sram_raddr_e,
   output logic                                         argmax_busy,
   output logic                                         argmax_done,
   output logic                                         argmax_valid,
   output logic [IDX_WIDTH-1:0]                         class_idx,
   output logic [DATA_WIDTH-1:0]                        class_score
);

   localparam int DN = DATA_NUM_PER_SRAM_ADDR;
   localparam int NW = (CLASS_NUM + DN - 1) / DN;
   localparam int CW = $clog2(NW + 1);
   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [CW-1:0]         NW_C = CW'(NW);

   if ((CLASS_NUM < 1) || (CLASS_NUM > 64)) begin : g_class_chk
      $error("fc_argmax: CLASS_NUM must be in 1..64");
   end
   if ((CLASS_NUM - 1) >= (1 << IDX_WIDTH)) begin : g_idx_chk
      $error("fc_argmax: IDX_WIDTH too small to hold CLASS_NUM-1");
   end

   // Handshake: argmax_start is a level sampled only in IDLE; busy rises on the accepting
   // edge, done pulses for exactly one cycle, valid stays high until the next accepted start.
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t                        state_q, state_d;
   logic [CW-1:0]                 cnt_q, cnt_d;
   logic                          v1_q, v1_d, v2_q, v2_d;
   logic [CW-1:0]                 w1_q, w1_d, w2_q, w2_d;
   logic signed [DATA_WIDTH-1:0]  run_score_q, run_score_d;
   logic [IDX_WIDTH-1:0]          run_idx_q, run_idx_d;
   logic [ADDR_WIDTH-1:0]         raddr_q, raddr_d;
   logic                          busy_q, busy_d, done_q, done_d, valid_q, valid_d;
   logic [IDX_WIDTH-1:0]          idx_q, idx_d;
   logic signed [DATA_WIDTH-1:0]  score_q, score_d;

   logic signed [DATA_WIDTH-1:0]  loc_score, lane, mrg_score;
   logic [IDX_WIDTH-1:0]          loc_idx, mrg_idx;
   logic                          take_loc;

   // Lane reduction of the returning word; padding lanes past CLASS_NUM never win.
   always_comb begin
      loc_score = sram_rdata_e[DATA_WIDTH*DN-1 -: DATA_WIDTH];
      loc_idx   = IDX_WIDTH'(int'(w2_q) * DN);
      lane      = '0;
      for (int j = 1; j < DN; j++) begin
         lane = sram_rdata_e[DATA_WIDTH*(DN-j)-1 -: DATA_WIDTH];
         if (((int'(w2_q) * DN + j) < CLASS_NUM) && (lane > loc_score)) begin
            loc_score = lane;
            loc_idx   = IDX_WIDTH'(int'(w2_q) * DN + j);
         end
      end
   end

   // The first word seeds the running max, so no sentinel value is needed.
   always_comb begin
      take_loc  = (w2_q == '0) || (loc_score > run_score_q);
      mrg_score = take_loc ? loc_score : run_score_q;
      mrg_idx   = take_loc ? loc_idx   : run_idx_q;
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      raddr_d     = raddr_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      valid_d     = valid_q;
      idx_d       = idx_q;
      score_d     = score_q;
      v1_d        = 1'b0;
      w1_d        = cnt_q;
      v2_d        = v1_q;
      w2_d        = w1_q;
      run_score_d = v2_q ? mrg_score : run_score_q;
      run_idx_d   = v2_q ? mrg_idx   : run_idx_q;
      case (state_q)
         S_IDLE: begin
            raddr_d = BASE;
            if (argmax_start) begin
               valid_d = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            if (cnt_q == NW_C) begin
               state_d = S_DRAIN;
            end else begin
               raddr_d = BASE + ADDR_WIDTH'(cnt_q);
               v1_d    = 1'b1;
               cnt_d   = cnt_q + CW'(1);
            end
         end
         S_DRAIN: begin
            // The last word is on rdata now; commit the merged result on this edge.
            state_d = S_DONE;
            done_d  = 1'b1;
            valid_d = 1'b1;
            busy_d  = 1'b0;
            raddr_d = BASE;
            idx_d   = mrg_idx;
            score_d = mrg_score;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge srstn) begin
      if (srstn) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         w1_q        <= '0;
         w2_q        <= '0;
         run_score_q <= '0;
         run_idx_q   <= '0;
         raddr_q     <= BASE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         idx_q       <= '0;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         w1_q        <= w1_d;
         w2_q        <= w2_d;
         run_score_q <= run_score_d;
         run_idx_q   <= run_idx_d;
         raddr_q     <= raddr_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         idx_q       <= idx_d;
         score_q     <= score_d;
      end
   end

   assign sram_raddr_e = raddr_q;
   assign argmax_busy  = busy_q;
   assign argmax_done  = done_q;
   assign argmax_valid = valid_q;
   assign class_idx    = idx_q;
   assign class_score  = score_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Self-checking bench for fc_argmax: SRAM e model, cycle-level reference model of the
// scan timing and of the argmax result, directed cases and randomized runs.
module tb_fc_argmax;
  localparam int CN = 10;
  localparam int NW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] rdata = '0;
  logic [9:0]  raddr;
  logic        busy, done, valid;
  logic [3:0]  idx;
  logic [7:0]  score;

  fc_argmax dut (
    .clk(clk), .srstn(rst), .argmax_start(start), .sram_rdata_e(rdata),
    .sram_raddr_e(raddr), .argmax_busy(busy), .argmax_done(done),
    .argmax_valid(valid), .class_idx(idx), .class_score(score)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // SRAM e with one-cycle read latency
  logic [31:0] mem [16];
  always @(posedge clk) rdata <= mem[raddr[3:0]];

  // scoreboard counters
  int n_chk = 0;
  int n_pass = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // class scores currently stored in SRAM
  logic [7:0] sc [CN];

  function automatic void ref_max(output logic [3:0] ri, output logic [7:0] rs);
    int best = 0;
    for (int k = 1; k < CN; k++)
      if ($signed(sc[k]) > $signed(sc[best])) best = k;
    ri = 4'(best);
    rs = sc[best];
  endfunction

  // reference model: a run lasts NW+2 edges after the accepting one
  int         m_t = 0;
  bit         m_run = 0;
  bit         was_done;
  logic       m_busy = 0, m_done = 0, m_valid = 0;
  logic [3:0] m_idx = 0;
  logic [7:0] m_score = 0;
  logic [9:0] m_raddr = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_t = 0; m_busy = 0; m_done = 0; m_valid = 0;
      m_idx = 0; m_score = 0; m_raddr = 0;
    end else begin
      was_done = m_done;
      m_done = 0;
      if (m_run) begin
        m_t++;
        if (m_t <= NW) m_raddr = 10'(m_t - 1);
        if (m_t == NW + 2) begin
          m_run = 0; m_done = 1; m_valid = 1; m_busy = 0; m_raddr = 0;
          ref_max(m_idx, m_score);
        end
      end else if (start && !was_done) begin
        m_run = 1; m_t = 0; m_busy = 1; m_valid = 0;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("valid", valid, m_valid);
    chk("class_idx", idx, m_idx);
    chk("class_score", score, m_score);
    chk("raddr", raddr, m_raddr);
    if (done === 1'b1) done_cnt++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [7:0] pad0, input logic [7:0] pad1);
    for (int w = 0; w < NW; w++) begin
      logic [31:0] word = '0;
      for (int j = 0; j < 4; j++) begin
        int k = w * 4 + j;
        logic [7:0] b;
        if (k < CN) b = sc[k];
        else if (j == 2) b = pad0;
        else b = pad1;
        word[8*(4-j)-1 -: 8] = b;
      end
      mem[w] = word;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_done_seen"}, done, 1'b1);
  endtask

  task automatic lit(input string nm, input logic [3:0] ei, input logic [7:0] es);
    chk({nm, "_idx"}, idx, ei);
    chk({nm, "_score"}, score, es);
    chk({nm, "_model_idx"}, m_idx, ei);
    chk({nm, "_model_score"}, m_score, es);
  endtask

  initial begin
    int n;
    int d0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int k = 0; k < CN; k++) sc[k] = 8'h00;
    rst = 1'b1;
    tick(); tick();
    chk("reset_busy", busy, 1'b0);
    chk("reset_valid", valid, 1'b0);
    chk("reset_idx", idx, 4'd0);
    chk("reset_raddr", raddr, 10'd0);
    rst = 1'b0;
    tick();

    // 1: mixed scores, latency check
    sc = '{8'hFD, 8'd5, 8'd12, 8'd7, 8'h80, 8'h7F, 8'd0, 8'd1, 8'd2, 8'd3};
    load(8'h11, 8'h22);
    tick();
    pulse_start();
    wait_done("t1", n);
    chk("t1_latency", n, NW + 2);
    lit("t1", 4'd5, 8'h7F);
    tick();

    // 2: all equal, lowest index wins
    for (int k = 0; k < CN; k++) sc[k] = 8'hEC;
    load(8'hEC, 8'hEC);
    tick();
    pulse_start();
    wait_done("t2", n);
    lit("t2", 4'd0, 8'hEC);
    tick();

    // 3: signed compare
    for (int k = 0; k < CN; k++) sc[k] = 8'h90;
    sc[3] = 8'h80; sc[4] = 8'h7F;
    load(8'h00, 8'h00);
    tick();
    pulse_start();
    wait_done("t3", n);
    lit("t3", 4'd4, 8'h7F);
    tick();

    // 4: padding lanes ignored
    for (int k = 0; k < CN; k++) sc[k] = 8'($signed($urandom_range(0, 137)) - 128);
    sc[9] = 8'd10;
    load(8'h7F, 8'h7F);
    tick();
    pulse_start();
    wait_done("t4", n);
    lit("t4", 4'd9, 8'd10);
    tick();

    // 5a: start while busy ignored
    sc = '{8'hFD, 8'd5, 8'd12, 8'd7, 8'h80, 8'h7F, 8'd0, 8'd1, 8'd2, 8'd3};
    load(8'h7F, 8'h7F);
    tick();
    d0 = done_cnt;
    pulse_start();
    tick();
    pulse_start();
    wait_done("t5a", n);
    lit("t5a", 4'd5, 8'h7F);
    repeat (8) tick();
    chk("t5a_single_done", done_cnt - d0, 1);

    // 5b: reset mid-scan
    d0 = done_cnt;
    pulse_start();
    tick();
    pulse_start();
    rst = 1'b1;
    #1;
    chk("t5b_busy", busy, 1'b0);
    chk("t5b_valid", valid, 1'b0);
    chk("t5b_idx", idx, 4'd0);
    chk("t5b_score", score, 8'd0);
    tick(); tick();
    rst = 1'b0;
    repeat (8) tick();
    chk("t5b_no_done", done_cnt - d0, 0);
    pulse_start();
    wait_done("t5c", n);
    lit("t5c", 4'd5, 8'h7F);
    tick();

    // 6: back-to-back, start during DONE ignored, next IDLE cycle accepted
    for (int k = 0; k < CN; k++) sc[k] = 8'd0;
    sc[8] = 8'd50;
    load(8'h7F, 8'h7F);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    chk("t6_valid_drop", valid, 1'b0);
    chk("t6_old_idx_held", idx, 4'd5);
    wait_done("t6", n);
    lit("t6", 4'd8, 8'd50);
    tick();

    // randomized runs
    for (int r = 0; r < 60; r++) begin
      int mode = $urandom_range(0, 7);
      for (int k = 0; k < CN; k++) sc[k] = 8'($urandom_range(0, 255));
      if (mode == 1) sc[$urandom_range(0, CN - 1)] = sc[$urandom_range(0, CN - 1)];
      load(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(1, 3)) tick();
      pulse_start();
      if (mode == 0) begin
        repeat ($urandom_range(0, NW + 1)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
      end else begin
        if (mode == 2) begin
          repeat ($urandom_range(0, NW)) tick();
          pulse_start();
        end
        wait_done("rnd", n);
        tick();
      end
    end

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
